uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `uart_tx_8n1` transmitter among `N_REQ` byte producers, such as the core debug dump, CSR trace and a future MMIO port. It sits between the core's producers and `uart_tx_8n1`, and replaces the ad-hoc send-once logic in the core. Each byte is granted round-robin, launched with a one-cycle `senddata` pulse, and held until `txdone` or a watchdog timeout before the next grant.

## Interface
- `N_REQ`, default 2: number of requesters (2–8).
- `TIMEOUT`, default 60000: cycles to wait for `txdone` after a send. It must exceed one frame (50 MHz / 9600 baud × 10 bits ≈ 52083).
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  byte pending, one bit per requester.
- `req_data`  in  8·N_REQ  byte for requester i at bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-cycle pulse: that requester's byte has been taken.
- `uart_txbyte`  out  8  to `uart_tx_8n1.txbyte`.
- `uart_send`  out  1  to `uart_tx_8n1.senddata`; one-cycle pulse.
- `uart_txdone`  in  1  from `uart_tx_8n1.txdone`; one-cycle pulse at end of stop bit.
- `busy`  out  1  high while a frame is outstanding or a drain is in progress.
- `grant_id`  out  clog2(N_REQ) (min 1)  requester of the current or last frame.
- `timeout_err`  out  1  sticky; set when a watchdog expires in WAIT.

## Operation
- States: DRAIN, IDLE, WAIT.
- **Reset values:**
  - state goes to DRAIN; `req_ready`=0, `uart_send`=0, `uart_txbyte`=0, `busy`=1, `grant_id`=0, `timeout_err`=0.
  - Round-robin pointer set to N_REQ−1, so requester 0 wins first.
  - Watchdog counter cleared to 0.
- **DRAIN:**
  - `uart_tx_8n1` has no reset, so a frame may still be shifting after `rst`.
  - Wait for `txdone` or for the counter to reach TIMEOUT−1, then go to IDLE and drop `busy`.
  - Expiry here does not set `timeout_err`.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit searching upward from pointer+1, wrapping at N_REQ.
  - At the edge, register:
    - `uart_txbyte` = that requester's byte;
    - `uart_send`=1;
    - `req_ready[g]`=1;
    - `grant_id`=g, pointer=g, `busy`=1;
    - counter=0;
    - state goes to WAIT.
  - `txdone` is ignored in IDLE.
- **WAIT:**
  - `uart_send` and `req_ready` return to 0; the counter increments every cycle.
  - On `txdone`=1: go to IDLE and set `busy`=0.
  - Else, when the counter reaches TIMEOUT−1: go to IDLE, set `busy`=0 and `timeout_err`=1.
  - `req_valid` changes are ignored in WAIT.
- **Requester protocol:**
  - Hold `req_valid` and data stable until `req_ready`.
  - Deassert, or present the next byte, in the cycle after `req_ready`.
  - If `req_valid` drops before being granted, nothing is sent and no error is raised.
- **Width:** the counter is clog2(TIMEOUT) bits and saturates, never wraps.
- `timeout_err` clears only on `rst`.

## Timing
- Grant latency: valid seen high in IDLE at edge k gives `uart_send`/`req_ready` high during cycle k+1, for exactly one cycle.
- `txdone` seen at edge m gives IDLE with `busy`=0 in cycle m+1. The earliest next `uart_send` is cycle m+2, so there is at least one idle cycle between frames.
- `txdone` and the watchdog terminal count at the same edge: `txdone` wins and no error is flagged.
- `txdone` in the same cycle as `uart_send` is ignored; it belongs to the previous frame. The counter starts the cycle after the send.
- `rst` during WAIT aborts the frame with no `req_ready` reissue; the controller re-enters DRAIN.
- All outputs are registered. No combinational path runs from any input to any output.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum (DRAIN, IDLE, WAIT);
  - the default TIMEOUT and CLOCK_FREQ/BAUD_RATE constants shared with `uart_tx_8n1`.
- Sub-module `rr_pick`: combinational round-robin selector taking `req`, `last` and producing `gnt_onehot`, `gnt_id`, `any`. It is reusable for future bus arbiters.
- The core instantiates `uart_tx_arbiter` plus `uart_tx_8n1`. The core's inline UART state machine is deleted.

## Test plan
Bench settings: N_REQ=2, TIMEOUT=100, and a UART model that pulses `txdone` 20 cycles after `senddata`.
- **Reset drain:** `rst` for 2 cycles, no `txdone` → `busy`=1 for 100 cycles, then 0. `timeout_err` stays 0 and no send occurs during DRAIN.
- **Single request:** requester 0 gives valid with 0x41 → next cycle `uart_send`=1, `uart_txbyte`=0x41, `req_ready`=01, `grant_id`=0. `busy` falls the cycle after `txdone`.
- **Fairness:** both requesters held valid (0x11, 0x22) for 4 frames → order is 0x11, 0x22, 0x11, 0x22, with ≥1 idle cycle between sends.
- **Timeout:** the model suppresses `txdone` → 100 cycles after the send, `busy`=0 and `timeout_err`=1. It stays 1 through the next frame and clears on `rst`.
- **Collision:** `txdone` coincides with counter = 99 → `timeout_err` stays 0.
- **Mid-frame reset:** `rst` at cycle 5 of WAIT → no `req_ready` reissue, DRAIN is entered, and the pending requester is granted after the drain ends.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Timing constants match the uart_tx_8n1 instance it feeds.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_e;

  localparam int CLOCK_FREQ      = 50_000_000;
  localparam int BAUD_RATE       = 9600;
  localparam int FRAME_BITS      = 10;
  localparam int TIMEOUT_DEFAULT = 60000;

  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request
// searching upward from last+1, wrapping at N.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N = 2,
  localparam int W = gid_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx_8n1 among N_REQ byte
// producers, with drain after reset and a txdone watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int GW      = gid_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         uart_txbyte,
  output logic               uart_send,
  input  logic               uart_txdone,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = '1;

  arb_state_e state, state_d;

  logic [CW-1:0]    cnt, cnt_d;
  logic [GW-1:0]    ptr, ptr_d;
  logic [7:0]       txbyte_d;
  logic             send_d, busy_d, err_d;
  logic [N_REQ-1:0] ready_d;
  logic [GW-1:0]    gid_d;

  logic [N_REQ-1:0] pick_oh;
  logic [GW-1:0]    pick_id;
  logic             pick_any;
  logic [7:0]       pick_byte;
  logic             term, done_ok;

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (req_valid),
    .last       (ptr),
    .gnt_onehot (pick_oh),
    .gnt_id     (pick_id),
    .any        (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_byte = req_data[8*i +: 8];
    end
  end

  assign term = (cnt == TERM);
  // a txdone alongside our own send belongs to the previous frame
  assign done_ok = uart_txdone && !uart_send;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_DRAIN;
      cnt         <= '0;
      ptr         <= GW'(N_REQ - 1);
      uart_txbyte <= '0;
      uart_send   <= 1'b0;
      req_ready   <= '0;
      busy        <= 1'b1;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      ptr         <= ptr_d;
      uart_txbyte <= txbyte_d;
      uart_send   <= send_d;
      req_ready   <= ready_d;
      busy        <= busy_d;
      grant_id    <= gid_d;
      timeout_err <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_DRAIN: if (uart_txdone || term) state_d = S_IDLE;
      S_IDLE:  if (pick_any) state_d = S_WAIT;
      S_WAIT:  if (done_ok || term) state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    cnt_d    = (cnt == CMAX) ? cnt : cnt + 1'b1;
    ptr_d    = ptr;
    txbyte_d = uart_txbyte;
    send_d   = 1'b0;
    ready_d  = '0;
    busy_d   = busy;
    gid_d    = grant_id;
    err_d    = timeout_err;
    unique case (state)
      S_DRAIN: begin
        if (uart_txdone || term) busy_d = 1'b0;
      end
      S_IDLE: begin
        if (pick_any) begin
          txbyte_d = pick_byte;
          send_d   = 1'b1;
          ready_d  = pick_oh;
          gid_d    = pick_id;
          ptr_d    = pick_id;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      S_WAIT: begin
        if (done_ok) begin
          busy_d = 1'b0;
        end else if (term) begin
          busy_d = 1'b0;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter against a
// deadline-based reference model and a txdone-delay UART model.
module tb_uart_tx_arbiter;

  localparam int N    = 2;
  localparam int T    = 100;
  localparam int MAXW = 400;

  localparam int M_DRAIN = 0;
  localparam int M_IDLE  = 1;
  localparam int M_WAIT  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_txbyte;
  logic           uart_send;
  logic           uart_txdone;
  logic           busy;
  logic [0:0]     grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_txbyte (uart_txbyte),
    .uart_send   (uart_send),
    .uart_txdone (uart_txdone),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int         g;
    logic [7:0] b;
  } sb_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] drv_q[N][$];
  logic [7:0] exp_q[N][$];
  sb_t        sb_q[$];
  logic [7:0] sent_log[$];
  int         send_cyc[$];
  bit         pop_pend[N];
  int         d_delay = 20;
  bit         suppress = 1'b1;
  bit         pend = 1'b0;
  int         rem = 0;

  int  e_n = 0, mode = M_DRAIN, start_e = 0;
  int  m_last = N - 1, m_gid = 0, m_g = 0;
  bit  m_busy = 1'b1, m_err = 1'b0, model_on = 1'b0;
  sb_t m_s;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    drv_q[i].push_back(b);
    exp_q[i].push_back(b);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int pending_bytes();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  // reference: a frame or drain ends on txdone or at start+T
  initial begin
    forever begin
      @(posedge clk);
      e_n++;
      if (rst) begin
        mode = M_DRAIN; start_e = e_n; m_last = N - 1;
        m_busy = 1'b1; m_err = 1'b0; m_gid = 0; model_on = 1'b1;
      end else begin
        case (mode)
          M_DRAIN: if (uart_txdone || e_n == start_e + T) begin
            mode = M_IDLE; m_busy = 1'b0;
          end
          M_IDLE: begin
            m_g = pick(req_valid, m_last);
            if (m_g >= 0) begin
              m_s.g = m_g;
              m_s.b = 8'h00;
              if (exp_q[m_g].size() > 0) m_s.b = exp_q[m_g].pop_front();
              sb_q.push_back(m_s);
              mode = M_WAIT; start_e = e_n; m_busy = 1'b1;
              m_gid = m_g; m_last = m_g;
            end
          end
          default: begin
            if (uart_txdone && e_n != start_e + 1) begin
              mode = M_IDLE; m_busy = 1'b0;
            end else if (e_n == start_e + T) begin
              mode = M_IDLE; m_busy = 1'b0; m_err = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // requesters and UART model, just after each falling edge
  initial begin
    uart_txdone = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    forever begin
      @(negedge clk);
      #1;
      uart_txdone = 1'b0;
      if (pend) begin
        rem--;
        if (rem <= 0) begin uart_txdone = 1'b1; pend = 1'b0; end
      end
      if (uart_send === 1'b1 && !suppress) begin
        if (d_delay == 0) uart_txdone = 1'b1;
        else begin pend = 1'b1; rem = d_delay; end
      end
      for (int i = 0; i < N; i++) begin
        if (pop_pend[i]) begin
          if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
          pop_pend[i] = 1'b0;
        end
        if (req_ready[i] === 1'b1) pop_pend[i] = 1'b1;
        req_valid[i]       = drv_q[i].size() > 0;
        req_data[8*i +: 8] = (drv_q[i].size() > 0) ? drv_q[i][0] : 8'h00;
      end
    end
  end

  // monitor
  initial begin
    sb_t          s;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (model_on) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (uart_send === 1'b1) begin
          send_cyc.push_back(cyc);
          sent_log.push_back(uart_txbyte);
          if (sb_q.size() == 0) begin
            chk("unexpected_send", 32'(uart_send), 32'd0);
          end else begin
            s = sb_q.pop_front();
            oh = '0;
            oh[s.g] = 1'b1;
            chk("send_byte", 32'(uart_txbyte), 32'(s.b));
            chk("send_ready", 32'(req_ready), 32'(oh));
          end
        end else begin
          chk("ready_quiet", 32'(req_ready), 32'd0);
          if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
            chk("missed_send", 32'(uart_send), 32'd1);
          end
        end
      end
    end
  end

  task automatic wait_send(output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (uart_send !== 1'b1 && n < MAXW);
    if (uart_send !== 1'b1) chk("send_wait_expired", 32'(uart_send), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < MAXW) begin @(negedge clk); n++; end
    if (busy !== 1'b0) chk("idle_wait_expired", 32'(busy), 32'd0);
  endtask

  task automatic drain_all(input int lim);
    int n = 0;
    while ((busy !== 1'b0 || pending_bytes() > 0 || sb_q.size() > 0)
           && n < lim) begin
      @(negedge clk); n++;
    end
    chk("drain_all_left", 32'(pending_bytes()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, c, base;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_err", 32'(timeout_err), 32'd0);
    wait_idle(n);
    chk("drain_cycles", 32'(n), 32'd100);
    chk("drain_no_send", 32'(sent_log.size()), 32'd0);

    suppress = 1'b0; d_delay = 20;
    @(negedge clk);
    push(0, 8'h41);
    wait_send(n);
    chk("single_latency", 32'(n), 32'd1);
    chk("single_byte", 32'(uart_txbyte), 32'h41);
    chk("single_ready", 32'(req_ready), 32'h1);
    wait_idle(n);
    chk("single_frame_len", 32'(n), 32'd21);

    d_delay = 99;
    repeat (3) @(negedge clk);
    push(1, 8'h5a);
    wait_send(n);
    wait_idle(n);
    chk("collision_len", 32'(n), 32'd100);
    chk("collision_err", 32'(timeout_err), 32'd0);

    d_delay = 20;
    repeat (3) @(negedge clk);
    base = sent_log.size();
    push(0, 8'h11); push(1, 8'h22); push(0, 8'h11); push(1, 8'h22);
    drain_all(MAXW);
    chk("fair_count", 32'(sent_log.size() - base), 32'd4);
    if (sent_log.size() == base + 4) begin
      chk("fair_0", 32'(sent_log[base]), 32'h11);
      chk("fair_1", 32'(sent_log[base+1]), 32'h22);
      chk("fair_2", 32'(sent_log[base+2]), 32'h11);
      chk("fair_3", 32'(sent_log[base+3]), 32'h22);
      for (int i = 1; i < 4; i++)
        chk("fair_gap", 32'(send_cyc[base+i] - send_cyc[base+i-1]), 32'd22);
    end

    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      d_delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 110))
                                            : int'($urandom_range(1, 40));
      push(int'($urandom_range(0, N - 1)), 8'($urandom));
      if ($urandom_range(0, 1) == 1)
        push(int'($urandom_range(0, N - 1)), 8'($urandom));
    end
    drain_all(20000);

    do_reset();
    chk("err_clear_rst", 32'(timeout_err), 32'd0);
    wait_idle(n);
    repeat (120) @(negedge clk);
    suppress = 1'b1; pend = 1'b0;
    push(0, 8'h77);
    wait_send(n);
    wait_idle(n);
    chk("timeout_len", 32'(n), 32'd100);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    suppress = 1'b0; d_delay = 20;
    push(1, 8'h88);
    wait_send(n);
    chk("err_sticky_send", 32'(timeout_err), 32'd1);
    wait_idle(n);
    chk("err_sticky_done", 32'(timeout_err), 32'd1);

    do_reset();
    chk("err_clear_rst2", 32'(timeout_err), 32'd0);
    wait_idle(n);
    @(negedge clk);
    base = sent_log.size();
    push(0, 8'ha5);
    wait_send(n);
    push(1, 8'h5c);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd1);
    wait_send(n);
    chk("midreset_byte", 32'(uart_txbyte), 32'h5c);
    chk("midreset_gid", 32'(grant_id), 32'd1);
    drain_all(MAXW);
    c = 0;
    for (int i = base; i < sent_log.size(); i++)
      if (sent_log[i] == 8'ha5) c++;
    chk("midreset_once", 32'(c), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=stuck exp=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
